// File: rtl/ad5662_pkg.sv
// Shared frame layout, power-down encodings and receiver state encoding
// for the AD5662 SPI receive decoder.
package ad5662_pkg;

    localparam int FRAME_BITS = 24;
    localparam int PD_LSB     = 16;
    localparam int PD_MSB     = 17;
    localparam int DATA_MSB   = 15;
    localparam int BITCNT_W   = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        PD_NORMAL    = 2'b00,
        PD_1K_GND    = 2'b01,
        PD_100K_GND  = 2'b10,
        PD_TRISTATE  = 2'b11
    } pd_mode_e;

    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        HOLD      = 2'd3
    } rx_state_e;

    function automatic logic is_last_bit(input logic [BITCNT_W-1:0] cnt);
        return cnt == BITCNT_W'(FRAME_BITS - 1);
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer for one SPI line, with rise/fall detection on the
// synchronized level.
module spi_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Chain resets low so a line already low at reset release never looks
    // like a fresh high level or a falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/ad5662_spi_rx.sv
// AD5662 SPI receive decoder: oversamples sclk/mosi/sync_n and commits each
// complete 24-bit frame as a DAC code plus power-down mode.
module ad5662_spi_rx
    import ad5662_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] RESET_CODE  = 16'h0000,
    parameter int          CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sclk,
    input  logic                 mosi,
    input  logic                 sync_n,
    output logic [15:0]          dac_code,
    output logic [1:0]           pd_mode,
    output logic                 code_valid,
    output logic                 frame_err,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] frame_cnt
);

    logic sclk_level_unused, sclk_rise_unused, sclk_fall;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;
    logic sync_level, sync_rise, sync_fall;

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (sclk),
        .level   (sclk_level_unused),
        .rise    (sclk_rise_unused),
        .fall    (sclk_fall)
    );

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (mosi),
        .level   (mosi_level),
        .rise    (mosi_rise_unused),
        .fall    (mosi_fall_unused)
    );

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sync_n (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (sync_n),
        .level   (sync_level),
        .rise    (sync_rise),
        .fall    (sync_fall)
    );

    rx_state_e             state_q, state_d;
    logic [PD_MSB-1:0]     shift_q;
    logic [PD_MSB:0]       shift_next;
    logic [BITCNT_W-1:0]   bitcnt_q;
    logic                  overrun_q;
    logic [15:0]           dac_q;
    pd_mode_e              pd_q;
    logic                  cv_q, fe_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic shift_en, commit, err, clr_cnt, set_ovr, clr_ovr;

    // Only the 18 meaningful bits are kept; DB23..DB18 fall off the top.
    assign shift_next = {shift_q, mosi_level};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_HIGH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        commit   = 1'b0;
        err      = 1'b0;
        clr_cnt  = 1'b0;
        set_ovr  = 1'b0;
        clr_ovr  = 1'b0;
        case (state_q)
            WAIT_HIGH: begin
                if (sync_level) state_d = IDLE;
            end
            IDLE: begin
                if (sync_fall) begin
                    state_d = SHIFT;
                    clr_cnt = 1'b1;
                    clr_ovr = 1'b1;
                end
            end
            SHIFT: begin
                // A sync_n rise outranks a coincident sclk fall.
                if (sync_rise) begin
                    err     = 1'b1;
                    state_d = IDLE;
                end else if (sclk_fall) begin
                    shift_en = 1'b1;
                    if (is_last_bit(bitcnt_q)) begin
                        commit  = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (sync_rise) begin
                    err     = overrun_q;
                    state_d = IDLE;
                end else if (sclk_fall) begin
                    set_ovr = 1'b1;
                end
            end
            default: state_d = WAIT_HIGH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q   <= '0;
            bitcnt_q  <= '0;
            overrun_q <= 1'b0;
            dac_q     <= RESET_CODE;
            pd_q      <= PD_NORMAL;
            cv_q      <= 1'b0;
            fe_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            cv_q <= commit;
            fe_q <= err;
            if (clr_cnt) begin
                bitcnt_q <= '0;
            end else if (shift_en) begin
                bitcnt_q <= bitcnt_q + BITCNT_W'(1);
            end
            if (shift_en) begin
                shift_q <= shift_next[PD_MSB-1:0];
            end
            if (clr_ovr) begin
                overrun_q <= 1'b0;
            end else if (set_ovr) begin
                overrun_q <= 1'b1;
            end
            if (commit) begin
                dac_q <= shift_next[DATA_MSB:0];
                pd_q  <= pd_mode_e'(shift_next[PD_MSB:PD_LSB]);
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign dac_code   = dac_q;
    assign pd_mode    = pd_q;
    assign code_valid = cv_q;
    assign frame_err  = fe_q;
    assign busy       = (state_q == SHIFT) || (state_q == HOLD);
    assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_ad5662_spi_rx.sv
// Directed bench for ad5662_spi_rx: a default instance plus a 2-bit frame
// counter instance share the same SPI stimulus.
`timescale 1ns/1ps
module tb_ad5662_spi_rx;

    logic clk = 1'b0;
    logic reset_n, sclk, mosi, sync_n;

    logic [15:0] dac_a, dac_b;
    logic [1:0]  pd_a, pd_b;
    logic        cv_a, cv_b, fe_a, fe_b, busy_a, busy_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    ad5662_spi_rx #(.SYNC_STAGES(2), .RESET_CODE(16'h0000), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .sclk(sclk), .mosi(mosi), .sync_n(sync_n),
        .dac_code(dac_a), .pd_mode(pd_a), .code_valid(cv_a), .frame_err(fe_a),
        .busy(busy_a), .frame_cnt(cnt_a)
    );

    ad5662_spi_rx #(.SYNC_STAGES(2), .RESET_CODE(16'h0000), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .sclk(sclk), .mosi(mosi), .sync_n(sync_n),
        .dac_code(dac_b), .pd_mode(pd_b), .code_valid(cv_b), .frame_err(fe_b),
        .busy(busy_b), .frame_cnt(cnt_b)
    );

    always #2.5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0, cv_cnt = 0, fe_cnt = 0, both_cnt = 0, last_cv_cyc = 0, fall_cyc = 0;

    // Pulse tally taken on the falling clock edge, away from DUT updates.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cv_a === 1'b1) begin
            cv_cnt      = cv_cnt + 1;
            last_cv_cyc = cyc;
        end
        if (fe_a === 1'b1) fe_cnt = fe_cnt + 1;
        if (cv_a === 1'b1 && fe_a === 1'b1) both_cnt = both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sel_low();
        sync_n = 1'b0;
        #20;
    endtask

    task automatic sel_high();
        #20;
        sync_n = 1'b1;
        #40;
    endtask

    // sclk idles high; mosi is set up while high and taken on the fall.
    task automatic clk_bits(input logic [31:0] word, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = word[i];
            #20;
            sclk = 1'b0;
            if (i == 0) fall_cyc = cyc;
            #20;
            sclk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [23:0] word);
        sel_low();
        clk_bits({8'h00, word}, 24);
        sel_high();
    endtask

    logic [23:0] frames [5];
    logic [1:0]  cnt_b_exp [5];

    initial begin
        frames[0] = 24'h000001; frames[1] = 24'h012222; frames[2] = 24'h023333;
        frames[3] = 24'h034444; frames[4] = 24'h005555;
        cnt_b_exp[0] = 2'd1; cnt_b_exp[1] = 2'd2; cnt_b_exp[2] = 2'd3;
        cnt_b_exp[3] = 2'd0; cnt_b_exp[4] = 2'd1;

        reset_n = 1'b0; sclk = 1'b1; mosi = 1'b0; sync_n = 1'b1;
        #1;
        #40;
        chk("rst_dac",   dac_a, 16'h0000);
        chk("rst_pd",    pd_a, 2'd0);
        chk("rst_cnt",   cnt_a, 16'd0);
        chk("rst_busy",  busy_a, 1'b0);
        chk("rst_pulse", {cv_a, fe_a}, 2'b00);

        reset_n = 1'b1;
        #100;
        chk("idle_dac",  dac_a, 16'h0000);
        chk("idle_cnt",  cnt_a, 16'd0);
        chk("idle_cv",   cv_cnt, 0);
        chk("idle_fe",   fe_cnt, 0);

        send_frame(24'h007FFF);
        chk("f1_dac",  dac_a, 16'h7FFF);
        chk("f1_pd",   pd_a, 2'd0);
        chk("f1_cnt",  cnt_a, 16'd1);
        chk("f1_cntb", cnt_b, 2'd1);
        chk("f1_cv",   cv_cnt, 1);
        chk("f1_lat",  last_cv_cyc - fall_cyc, 3);
        chk("f1_busy", busy_a, 1'b0);
        chk("f1_fe",   fe_cnt, 0);

        send_frame(24'h031234);
        chk("f2_dac", dac_a, 16'h1234);
        chk("f2_pd",  pd_a, 2'd3);
        chk("f2_cnt", cnt_a, 16'd2);
        chk("f2_cv",  cv_cnt, 2);

        sel_low();
        clk_bits(32'h0000_0155, 10);
        chk("ab_busy", busy_a, 1'b1);
        sel_high();
        chk("ab_fe",  fe_cnt, 1);
        chk("ab_dac", dac_a, 16'h1234);
        chk("ab_pd",  pd_a, 2'd3);
        chk("ab_cnt", cnt_a, 16'd2);
        chk("ab_cv",  cv_cnt, 2);

        sel_low();
        clk_bits({6'h00, 24'h00ABCD, 2'b11}, 26);
        chk("ov_cv",     cv_cnt, 3);
        chk("ov_dac",    dac_a, 16'hABCD);
        chk("ov_pd",     pd_a, 2'd0);
        chk("ov_fe_pre", fe_cnt, 1);
        chk("ov_busy",   busy_a, 1'b1);
        sel_high();
        chk("ov_fe",  fe_cnt, 2);
        chk("ov_cnt", cnt_a, 16'd3);
        chk("ov_dac2", dac_a, 16'hABCD);

        // 24th fall coincides with the sync_n rise
        sel_low();
        clk_bits(32'h0001_2D2D, 23);
        mosi = 1'b0;
        #20;
        sclk = 1'b0;
        sync_n = 1'b1;
        #20;
        sclk = 1'b1;
        #40;
        chk("sim_fe",   fe_cnt, 3);
        chk("sim_cv",   cv_cnt, 3);
        chk("sim_cnt",  cnt_a, 16'd3);
        chk("sim_dac",  dac_a, 16'hABCD);
        chk("sim_busy", busy_a, 1'b0);

        sel_low();
        sel_high();
        chk("z_fe", fe_cnt, 4);
        chk("z_cv", cv_cnt, 3);

        // Reset mid-frame, release with sync_n still low and sclk running
        sel_low();
        clk_bits(32'h0000_0FFF, 12);
        reset_n = 1'b0;
        clk_bits(32'h0000_003F, 6);
        chk("mr_busy", busy_a, 1'b0);
        chk("mr_dac",  dac_a, 16'h0000);
        chk("mr_pd",   pd_a, 2'd0);
        chk("mr_cnt",  cnt_a, 16'd0);
        chk("mr_cntb", cnt_b, 2'd0);
        reset_n = 1'b1;
        clk_bits(32'h00FF_FFFF, 24);
        sel_high();
        chk("wh_cv",  cv_cnt, 3);
        chk("wh_fe",  fe_cnt, 4);
        chk("wh_dac", dac_a, 16'h0000);
        chk("wh_cnt", cnt_a, 16'd0);

        for (int k = 0; k < 5; k++) begin
            send_frame(frames[k]);
            chk($sformatf("bb%0d_dac", k),  dac_a, frames[k][15:0]);
            chk($sformatf("bb%0d_pd", k),   pd_a, frames[k][17:16]);
            chk($sformatf("bb%0d_dacb", k), dac_b, frames[k][15:0]);
            chk($sformatf("bb%0d_cntb", k), cnt_b, cnt_b_exp[k]);
        end
        chk("end_cnt",  cnt_a, 16'd5);
        chk("end_cv",   cv_cnt, 8);
        chk("end_fe",   fe_cnt, 4);
        chk("end_both", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
